if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_if.sv | 14 +
 rtl/if_fetch.sv | 86 ++++++++
 tb/tb_if_fetch.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-unit bus bundle; memory port, decode port and redirect input
interface if_fetch_if;
  logic [31:0] if_a;
  logic        if_ok;
  logic [31:0] if_n;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        br_e;
  logic [31:0] br_a;
  modport master (output if_a, id_valid, id_inst, id_pc, input if_ok, if_n, id_ready, br_e, br_a);
  modport slave  (input if_a, id_valid, id_inst, id_pc, output if_ok, if_n, id_ready, br_e, br_a);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch FSM; clk/rst plus bus (memory if_a/if_ok/if_n, decode id_*, redirect br_e/br_a)
module if_fetch (
  input logic         clk,
  input logic         rst,
  if_fetch_if.master  bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DISC} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, inst_q, inst_d, pc_q, pc_d, tgt_q, tgt_d;
  logic        vld_q, vld_d, first_q, first_d, load;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    vld_d   = vld_q & ~bus.id_ready;
    tgt_d   = tgt_q;
    first_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_REQ: begin
        if (bus.br_e) begin
          vld_d = 1'b0;
          if (bus.br_a != addr_q) begin
            tgt_d   = bus.br_a;
            state_d = S_DISC;
            // if_ok seen in the next cycle may still belong to the abandoned address
            first_d = 1'b1;
          end
        end else state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.br_e) begin
          vld_d = 1'b0;
          if (bus.br_a != addr_q) begin
            tgt_d   = bus.br_a;
            state_d = S_DISC;
          end
        end else if (bus.if_ok) begin
          if (!vld_q || bus.id_ready) load = 1'b1;
          else state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (bus.br_e) begin
          vld_d   = 1'b0;
          addr_d  = bus.br_a;
          state_d = S_REQ;
        end else if (bus.id_ready) load = 1'b1;
      end
      default: begin
        tgt_d = bus.br_e ? bus.br_a : tgt_q;
        if (bus.if_ok && !first_q) begin
          addr_d  = tgt_d;
          state_d = S_REQ;
        end
      end
    endcase
    vld_d   = load ? 1'b1 : vld_d;
    addr_d  = load ? addr_q + 32'd4 : addr_d;
    state_d = load ? S_REQ : state_d;
    inst_d  = load ? bus.if_n : inst_q;
    pc_d    = load ? addr_q : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      first_q <= first_d;
    end
  end
  assign bus.if_a     = addr_q;
  assign bus.id_valid = vld_q;
  assign bus.id_inst  = inst_q;
  assign bus.id_pc    = pc_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch with a one-wait-cycle memory model
module tb_if_fetch;
  logic        clk, rst;
  logic [31:0] last_a;
  int          cnt;
  int          n_cmp, n_err;
  if_fetch_if bus ();
  if_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    last_a     = '0;
    cnt        = 0;
    bus.if_ok  = 1'b0;
  end
  // memory: an address change drops if_ok on the following edge, which then returns one edge later
  always @(posedge clk) begin
    if (bus.if_a != last_a) begin
      last_a    <= bus.if_a;
      cnt       <= 0;
      bus.if_ok <= 1'b0;
    end else if (cnt < 1) begin
      cnt       <= cnt + 1;
      bus.if_ok <= 1'b1;
    end else bus.if_ok <= 1'b1;
  end
  assign bus.if_n = last_a + 32'h13;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] a);
    chk({tag, "_valid"}, {31'd0, bus.id_valid}, {31'd0, v});
    chk({tag, "_pc"}, bus.id_pc, pc);
    chk({tag, "_inst"}, bus.id_inst, inst);
    chk({tag, "_if_a"}, bus.if_a, a);
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.id_ready = 1'b1;
    bus.br_e = 1'b0;
    bus.br_a = '0;
    tick();
    tick();
    chk_id("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    chk("req_ignores_ok", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk_id("first", 1'b1, 32'h0, 32'h13, 32'h4);
    tick();
    chk_id("stale_ok", 1'b0, 32'h0, 32'h13, 32'h4);
    tick();
    chk("wait_low", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk_id("pc4", 1'b1, 32'h4, 32'h17, 32'h8);
    bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_id("stall", 1'b1, 32'h4, 32'h17, 32'h8);
    end
    bus.id_ready = 1'b1;
    tick();
    chk_id("full_xfer", 1'b1, 32'h8, 32'h1b, 32'hc);
    tick();
    tick();
    tick();
    chk_id("pc12", 1'b1, 32'hc, 32'h1f, 32'h10);
    tick();
    bus.br_e = 1'b1;
    bus.br_a = 32'h100;
    tick();
    chk_id("br_wait", 1'b0, 32'hc, 32'h1f, 32'h10);
    bus.br_e = 1'b0;
    tick();
    chk_id("disc_redir", 1'b0, 32'hc, 32'h1f, 32'h100);
    tick();
    chk("no_old_a", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk("no_old_b", {31'd0, bus.id_valid}, 32'd0);
    tick();
    chk_id("pc100", 1'b1, 32'h100, 32'h113, 32'h104);
    bus.br_e = 1'b1;
    bus.br_a = 32'h50;
    tick();
    chk_id("br_req", 1'b0, 32'h100, 32'h113, 32'h104);
    bus.br_a = 32'h20;
    tick();
    bus.br_e = 1'b0;
    tick();
    chk_id("disc_overwrite", 1'b0, 32'h100, 32'h113, 32'h20);
    tick();
    bus.br_e = 1'b1;
    bus.br_a = 32'h20;
    tick();
    chk_id("br_same", 1'b0, 32'h100, 32'h113, 32'h20);
    bus.br_e = 1'b0;
    tick();
    chk_id("pc20", 1'b1, 32'h20, 32'h33, 32'h24);
    bus.br_e = 1'b1;
    bus.br_a = 32'hffff_fffc;
    tick();
    bus.br_e = 1'b0;
    tick();
    tick();
    chk("to_top", bus.if_a, 32'hffff_fffc);
    tick();
    tick();
    tick();
    chk_id("wrap", 1'b1, 32'hffff_fffc, 32'h0000_000f, 32'h0);
    bus.id_ready = 1'b0;
    tick();
    tick();
    tick();
    chk_id("full_hold", 1'b1, 32'hffff_fffc, 32'h0000_000f, 32'h0);
    bus.br_e = 1'b1;
    bus.br_a = 32'h300;
    tick();
    chk_id("br_full", 1'b0, 32'hffff_fffc, 32'h0000_000f, 32'h300);
    bus.br_e = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    bus.br_e = 1'b1;
    bus.br_a = 32'h400;
    tick();
    chk_id("to_disc", 1'b0, 32'hffff_fffc, 32'h0000_000f, 32'h300);
    bus.br_e = 1'b0;
    rst = 1'b1;
    tick();
    chk_id("rst_disc", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk_id("after_rst", 1'b1, 32'h0, 32'h13, 32'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
